hdmi_decode: RTL and testbench

//  Receive-side counterpart of the HDMI TMDS transmit path. Takes three word-aligned 10-bit TMDS

---
 rtl/hdmi_pkg.sv | 20 ++
 rtl/tmds_decode_ch.sv | 59 +++++
 rtl/hdmi_decode.sv | 159 +++++++++++++++
 tb/tb_hdmi_decode.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared TMDS control tokens and decode enums
package hdmi_pkg;

    localparam logic [9:0] TMDS_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        CLS_CTRL,
        CLS_DATA,
        CLS_MIX
    } cycle_class_t;

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } lock_state_t;

endpackage

// File: rtl/tmds_decode_ch.sv
// rtl/tmds_decode_ch.sv - one TMDS channel: token detect and 10b->8b data decode, registered
module tmds_decode_ch
    import hdmi_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic [9:0] i_symbol,
    output logic [7:0] o_data,
    output logic       o_is_ctrl,
    output logic [1:0] o_ctrl
);

    logic [7:0] w_m;
    logic [7:0] w_d;
    logic       w_is_ctrl;
    logic [1:0] w_ctrl;

    logic [7:0] r_data;
    logic       r_is_ctrl;
    logic [1:0] r_ctrl;

    always_comb begin
        w_m    = i_symbol[9] ? ~i_symbol[7:0] : i_symbol[7:0];
        w_d    = 8'h00;
        w_d[0] = w_m[0];
        for (int i = 1; i < 8; i++) begin
            w_d[i] = i_symbol[8] ? (w_m[i] ^ w_m[i-1]) : ~(w_m[i] ^ w_m[i-1]);
        end
    end

    always_comb begin
        w_is_ctrl = 1'b1;
        w_ctrl    = 2'b00;
        case (i_symbol)
            TMDS_TOKEN_00: w_ctrl = 2'b00;
            TMDS_TOKEN_01: w_ctrl = 2'b01;
            TMDS_TOKEN_10: w_ctrl = 2'b10;
            TMDS_TOKEN_11: w_ctrl = 2'b11;
            default:       w_is_ctrl = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_data    <= 8'h00;
            r_is_ctrl <= 1'b0;
            r_ctrl    <= 2'b00;
        end else begin
            r_data    <= w_d;
            r_is_ctrl <= w_is_ctrl;
            r_ctrl    <= w_ctrl;
        end
    end

    assign o_data    = r_data;
    assign o_is_ctrl = r_is_ctrl;
    assign o_ctrl    = r_ctrl;

endmodule

// File: rtl/hdmi_decode.sv
// rtl/hdmi_decode.sv - TMDS receive decode with link-lock qualification (option: HDMI_DECODE_ERRCNT_EN)
module hdmi_decode
    import hdmi_pkg::*;
#(
    parameter int MIN_CTRL    = 12,
    parameter int LOCK_BLANKS = 4,
    parameter int ERR_MAX     = 8
) (
    input  logic        i_p_clk,
    input  logic        i_resetn,
    input  logic [9:0]  i_tmds_red,
    input  logic [9:0]  i_tmds_green,
    input  logic [9:0]  i_tmds_blue,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_vsync,
    output logic        o_hsync,
    output logic        o_active_area,
    output logic        o_locked
`ifdef HDMI_DECODE_ERRCNT_EN
    ,
    output logic [15:0] o_err_count
`endif
);

    localparam int RUN_W  = $clog2(MIN_CTRL + 1);
    localparam int GOOD_W = $clog2(LOCK_BLANKS + 1);
    localparam int ERR_W  = $clog2(ERR_MAX + 1);

    logic [7:0] w_d0, w_d1, w_d2;
    logic       w_c0, w_c1, w_c2;
    logic [1:0] w_tok0, w_unused_tok1, w_unused_tok2;

    tmds_decode_ch u_ch0 (.i_clk(i_p_clk), .i_resetn(i_resetn), .i_symbol(i_tmds_red),
                          .o_data(w_d0), .o_is_ctrl(w_c0), .o_ctrl(w_tok0));
    tmds_decode_ch u_ch1 (.i_clk(i_p_clk), .i_resetn(i_resetn), .i_symbol(i_tmds_green),
                          .o_data(w_d1), .o_is_ctrl(w_c1), .o_ctrl(w_unused_tok1));
    tmds_decode_ch u_ch2 (.i_clk(i_p_clk), .i_resetn(i_resetn), .i_symbol(i_tmds_blue),
                          .o_data(w_d2), .o_is_ctrl(w_c2), .o_ctrl(w_unused_tok2));

    cycle_class_t w_class;
    logic         w_valid_blank, w_bad_blank, w_mix, w_active;

    lock_state_t  r_state, w_state_nxt;
    logic [RUN_W-1:0]  r_ctrl_run;
    logic [GOOD_W-1:0] r_good, w_good_nxt;
    logic [ERR_W-1:0]  r_err, w_err_nxt;

    logic [7:0] r_red, r_green, r_blue;
    logic       r_vsync, r_hsync, r_active;

    always_comb begin
        if (w_c0 && w_c1 && w_c2)        w_class = CLS_CTRL;
        else if (!w_c0 && !w_c1 && !w_c2) w_class = CLS_DATA;
        else                              w_class = CLS_MIX;
    end

    // A non-zero run means the previous cycle was CTRL, so DATA here is a blanking edge.
    assign w_mix         = (w_class == CLS_MIX);
    assign w_valid_blank = (w_class == CLS_DATA) && (r_ctrl_run >= RUN_W'(MIN_CTRL));
    assign w_bad_blank   = (w_class == CLS_DATA) && (r_ctrl_run != '0)
                           && (r_ctrl_run < RUN_W'(MIN_CTRL));

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_err_nxt   = r_err;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_valid_blank)             w_good_nxt = r_good + GOOD_W'(1);
                else if (w_bad_blank || w_mix) w_good_nxt = '0;
                if (w_good_nxt == GOOD_W'(LOCK_BLANKS)) begin
                    w_state_nxt = ST_LOCKED;
                    w_good_nxt  = '0;
                    w_err_nxt   = '0;
                end
            end
            ST_LOCKED: begin
                if (w_valid_blank)
                    w_err_nxt = '0;
                else if ((w_bad_blank || w_mix) && (r_err != ERR_W'(ERR_MAX)))
                    w_err_nxt = r_err + ERR_W'(1);
                if (w_err_nxt == ERR_W'(ERR_MAX)) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_good_nxt  = '0;
                end
            end
            default: w_state_nxt = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge i_p_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= ST_UNLOCKED;
            r_good  <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge i_p_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_ctrl_run <= '0;
        end else if (w_class == CLS_CTRL) begin
            if (r_ctrl_run != RUN_W'(MIN_CTRL)) r_ctrl_run <= r_ctrl_run + RUN_W'(1);
        end else begin
            r_ctrl_run <= '0;
        end
    end

    // Gate on the post-update state so the pixel that completes lock is already shown.
    assign w_active = (w_state_nxt == ST_LOCKED) && (w_class == CLS_DATA);

    always_ff @(posedge i_p_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_red    <= 8'h00;
            r_green  <= 8'h00;
            r_blue   <= 8'h00;
            r_active <= 1'b0;
            r_vsync  <= 1'b0;
            r_hsync  <= 1'b0;
        end else begin
            r_red    <= w_active ? w_d0 : 8'h00;
            r_green  <= w_active ? w_d1 : 8'h00;
            r_blue   <= w_active ? w_d2 : 8'h00;
            r_active <= w_active;
            if (w_class == CLS_CTRL) begin
                r_vsync <= w_tok0[1];
                r_hsync <= w_tok0[0];
            end
        end
    end

`ifdef HDMI_DECODE_ERRCNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge i_p_clk or negedge i_resetn) begin
        if (!i_resetn)
            r_err_count <= 16'h0000;
        else if (w_mix && (r_err_count != 16'hFFFF))
            r_err_count <= r_err_count + 16'h0001;
    end

    assign o_err_count = r_err_count;
`endif

    assign o_red         = r_red;
    assign o_green       = r_green;
    assign o_blue        = r_blue;
    assign o_vsync       = r_vsync;
    assign o_hsync       = r_hsync;
    assign o_active_area = r_active;
    assign o_locked      = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_hdmi_decode.sv
// tb/tb_hdmi_decode.sv - directed bench for hdmi_decode with a cycle-level reference model
module tb_hdmi_decode;

    localparam int C_CTRL = 0;
    localparam int C_DATA = 1;
    localparam int C_MIX  = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [9:0]  t_r, t_g, t_b;
    logic [7:0]  o_red, o_green, o_blue;
    logic        o_vsync, o_hsync, o_active_area, o_locked;
    logic [15:0] ec_dut;
`ifdef HDMI_DECODE_ERRCNT_EN
    logic [15:0] o_err_count;
    assign ec_dut = o_err_count;
`else
    assign ec_dut = 16'h0000;
`endif

    hdmi_decode dut (
        .i_p_clk(clk), .i_resetn(resetn),
        .i_tmds_red(t_r), .i_tmds_green(t_g), .i_tmds_blue(t_b),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_vsync(o_vsync), .o_hsync(o_hsync),
        .o_active_area(o_active_area), .o_locked(o_locked)
`ifdef HDMI_DECODE_ERRCNT_EN
        , .o_err_count(o_err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r, g, b;
        logic        vs, hs, act, lk;
        logic [15:0] ec;
        bit          v;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t pipe0, pipe1;

    int   m_run, m_good, m_err, m_ec;
    bit   m_lk;
    logic m_vs, m_hs;

    function automatic logic [9:0] tok(input logic [1:0] v);
        case (v)
            2'b00:   tok = 10'b1101010100;
            2'b01:   tok = 10'b0010101011;
            2'b10:   tok = 10'b0101010100;
            default: tok = 10'b1010101011;
        endcase
    endfunction

    function automatic bit is_tok(input logic [9:0] s);
        is_tok = (s == tok(2'b00)) || (s == tok(2'b01)) || (s == tok(2'b10)) || (s == tok(2'b11));
    endfunction

    // Transmit-side encoding (no DC balancing) with an explicit choice of XOR/XNOR and inversion.
    function automatic logic [9:0] enc(input logic [7:0] d, input logic q8, input logic inv);
        logic [7:0] qm;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = q8 ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
        enc = {inv, q8, inv ? ~qm : qm};
    endfunction

    function automatic logic [9:0] data_sym(input logic [7:0] d);
        logic [9:0] s;
        logic q8, inv;
        q8  = 1'($urandom_range(1));
        inv = 1'($urandom_range(1));
        s = enc(d, q8, inv);
        if (is_tok(s)) s = enc(d, q8, ~inv);
        data_sym = s;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_good = 0; m_err = 0; m_ec = 0; m_lk = 0; m_vs = 0; m_hs = 0;
    endtask

    task automatic model_step(input int cls, input logic [7:0] r, g, b, input logic [1:0] tk0,
                              output exp_t e);
        bit valid, bad, mix;
        valid = (cls == C_DATA) && (m_run >= 12);
        bad   = (cls == C_DATA) && (m_run > 0) && (m_run < 12);
        mix   = (cls == C_MIX);
        if (cls == C_CTRL) begin
            m_run = (m_run < 12) ? m_run + 1 : 12;
            {m_vs, m_hs} = tk0;
        end else begin
            m_run = 0;
        end
        if (mix && m_ec < 65535) m_ec++;
        if (!m_lk) begin
            if (valid) m_good++;
            else if (bad || mix) m_good = 0;
            if (m_good == 4) begin m_lk = 1; m_err = 0; m_good = 0; end
        end else begin
            if (valid) m_err = 0;
            else if ((bad || mix) && m_err < 8) m_err++;
            if (m_err == 8) begin m_lk = 0; m_good = 0; end
        end
        e.v   = 1;
        e.act = m_lk && (cls == C_DATA);
        e.r   = e.act ? r : 8'h00;
        e.g   = e.act ? g : 8'h00;
        e.b   = e.act ? b : 8'h00;
        e.vs  = m_vs;
        e.hs  = m_hs;
        e.lk  = m_lk;
        e.ec  = 16'(m_ec);
    endtask

    task automatic compare_outputs(input exp_t e);
        check("red",    32'(o_red),         32'(e.r));
        check("green",  32'(o_green),       32'(e.g));
        check("blue",   32'(o_blue),        32'(e.b));
        check("vsync",  32'(o_vsync),       32'(e.vs));
        check("hsync",  32'(o_hsync),       32'(e.hs));
        check("active", 32'(o_active_area), 32'(e.act));
        check("locked", 32'(o_locked),      32'(e.lk));
`ifdef HDMI_DECODE_ERRCNT_EN
        check("err_count", 32'(ec_dut), 32'(e.ec));
`endif
    endtask

    task automatic cyc(input int cls, input logic [7:0] r, g, b, input logic [1:0] tk0);
        exp_t e;
        @(negedge clk);
        if (pipe1.v) compare_outputs(pipe1);
        pipe1 = pipe0;
        case (cls)
            C_CTRL: begin t_r = tok(tk0); t_g = tok(2'b01); t_b = tok(2'b10); end
            C_DATA: begin t_r = data_sym(r); t_g = data_sym(g); t_b = data_sym(b); end
            default: begin t_r = tok(tk0); t_g = data_sym(g); t_b = data_sym(b); end
        endcase
        model_step(cls, r, g, b, tk0, e);
        pipe0 = e;
    endtask

    task automatic data_run(input int n);
        for (int i = 0; i < n; i++)
            cyc(C_DATA, 8'($urandom), 8'($urandom), 8'($urandom), 2'b00);
    endtask

    task automatic blank(input int n_ctrl, input int n_data, input logic [1:0] tk);
        for (int i = 0; i < n_ctrl; i++) cyc(C_CTRL, 8'h00, 8'h00, 8'h00, tk);
        data_run(n_data);
    endtask

    task automatic release_reset();
        exp_t z;
        z = '{r: 8'h00, g: 8'h00, b: 8'h00, vs: 1'b0, hs: 1'b0, act: 1'b0, lk: 1'b0,
              ec: 16'h0000, v: 1'b1};
        @(negedge clk);
        model_reset();
        t_r = data_sym(8'h00); t_g = data_sym(8'h00); t_b = data_sym(8'h00);
        resetn = 1'b1;
        pipe1 = z;
        model_step(C_DATA, 8'h00, 8'h00, 8'h00, 2'b00, pipe0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rgb"},    32'({o_red, o_green, o_blue}), 32'h0);
        check({tag, "_sync"},   32'({o_vsync, o_hsync}), 32'h0);
        check({tag, "_active"}, 32'(o_active_area), 32'h0);
        check({tag, "_locked"}, 32'(o_locked), 32'h0);
        check({tag, "_errcnt"}, 32'(ec_dut), 32'h0);
    endtask

    initial begin
        logic [9:0] sym_a5;
        pipe0.v = 0;
        pipe1.v = 0;
        model_reset();
        t_r = 10'h000; t_g = 10'h000; t_b = 10'h000;

        // Pin the bench encoder: A5 with XOR, no inversion -> 01_0110_0011.
        sym_a5 = enc(8'hA5, 1'b1, 1'b0);
        check("enc_a5_xor", 32'(sym_a5), 32'h163);
        sym_a5 = enc(8'h00, 1'b0, 1'b1);
        check("enc_00_xnor_inv", 32'(sym_a5), 32'h255);

        #12;
        check_all_zero("reset");
        release_reset();

        // Acquire lock: four 12-cycle CTRL(00) blankings each followed by DATA.
        for (int k = 0; k < 3; k++) blank(12, 100, 2'b00);
        check("locked_after_3", 32'(o_locked), 32'h0);
        blank(12, 0, 2'b00);
        cyc(C_DATA, 8'h11, 8'h22, 8'h33, 2'b00);
        cyc(C_DATA, 8'h44, 8'h55, 8'h66, 2'b00);
        check("lock_edge_minus1", 32'(o_locked), 32'h0);
        cyc(C_DATA, 8'h77, 8'h88, 8'h99, 2'b00);
        check("lock_edge", 32'(o_locked), 32'h1);
        check("first_pixel", 32'({o_red, o_green, o_blue}), 32'h112233);
        data_run(97);

        // A5 on every channel.
        cyc(C_DATA, 8'hA5, 8'hA5, 8'hA5, 2'b00);
        cyc(C_DATA, 8'h01, 8'h02, 8'h03, 2'b00);
        cyc(C_DATA, 8'h04, 8'h05, 8'h06, 2'b00);
        check("a5_rgb", 32'({o_red, o_green, o_blue}), 32'hA5A5A5);
        check("a5_active", 32'(o_active_area), 32'h1);

        // Token 11 on ch0 within a full-length blanking.
        cyc(C_CTRL, 8'h00, 8'h00, 8'h00, 2'b11);
        cyc(C_CTRL, 8'h00, 8'h00, 8'h00, 2'b11);
        cyc(C_CTRL, 8'h00, 8'h00, 8'h00, 2'b11);
        check("tok11_sync", 32'({o_vsync, o_hsync}), 32'h3);
        check("tok11_active", 32'(o_active_area), 32'h0);
        check("tok11_rgb", 32'({o_red, o_green, o_blue}), 32'h0);
        blank(9, 20, 2'b11);
        check("tok11_sync_held", 32'({o_vsync, o_hsync}), 32'h3);

        // Eight MIX cycles force UNLOCKED; DATA afterwards stays blanked.
        for (int i = 0; i < 8; i++) cyc(C_MIX, 8'h00, 8'h5A, 8'hC3, 2'b10);
        data_run(10);
        check("mix_unlocked", 32'(o_locked), 32'h0);
        check("mix_blanked", 32'(o_active_area), 32'h0);
`ifdef HDMI_DECODE_ERRCNT_EN
        check("mix_errcnt", 32'(ec_dut), 32'h8);
`endif

        // Three good blankings, one short (11), then lock needs four more.
        for (int k = 0; k < 3; k++) blank(12, 30, 2'b01);
        blank(11, 30, 2'b01);
        for (int k = 0; k < 3; k++) blank(12, 30, 2'b00);
        check("short_blank_no_lock", 32'(o_locked), 32'h0);
        blank(12, 30, 2'b00);
        check("relock", 32'(o_locked), 32'h1);

        // Asynchronous reset in the middle of an active line.
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        pipe0.v = 0;
        pipe1.v = 0;
        release_reset();
        blank(12, 20, 2'b00);
        check("post_reset_unlocked", 32'(o_locked), 32'h0);
        cyc(C_DATA, 8'h00, 8'h00, 8'h00, 2'b00);
        cyc(C_DATA, 8'h00, 8'h00, 8'h00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
